i2c_color_slave_rx: RTL and testbench

- I2C slave receiver: the target-side counterpart of the color-sensor I2C write transaction.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit write address, ACKs each byte and assembles the 10 data bytes into five 16-bit channel words (clear, red, green, blue, infrared).
- Publishes the words atomically on a valid STOP. Sits in the test/bring-up environment or a receiving SoC as the sensor-data sink.

---
 rtl/i2c_color_slave_rx.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_i2c_color_slave_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_color_slave_rx.sv
// i2c_color_slave_rx: I2C write-only slave that receives a ten-byte color
// sensor frame. It ACKs a matching address and each data byte, and publishes
// five 16-bit channel words (clear, red, green, blue, infrared) together on
// a valid STOP.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a FILTER_LEN-sample
// stability filter on SCL and SDA after the synchronizers.
module i2c_color_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = 10,
  parameter int FILTER_LEN  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [6:0]  own_address,
  input  logic        endian,
  output logic [15:0] clear_data,
  output logic [15:0] red_data,
  output logic [15:0] green_data,
  output logic [15:0] blue_data,
  output logic [15:0] infrared_data,
  output logic        data_valid,
  output logic        bsy,
  output logic        frame_error
);

  localparam int BCW = $clog2(NUM_BYTES + 1);
  localparam logic [BCW-1:0] LAST_CNT = BCW'(NUM_BYTES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  // Builds a channel word from its two staging bytes in arrival order.
  function automatic logic [15:0] map_word(input logic hi_first,
                                           input logic [7:0] first_byte,
                                           input logic [7:0] second_byte);
    if (hi_first) begin
      map_word = {first_byte, second_byte};
    end else begin
      map_word = {second_byte, first_byte};
    end
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_f_s, sda_f_s;
  logic scl_d_r, sda_d_r;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  // Input synchronizers; reset to the idle-high bus level so no false event fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [FILTER_LEN-2:0] scl_hist_r, sda_hist_r;
  logic [FILTER_LEN-1:0] scl_win_s, sda_win_s;
  logic scl_flt_r, sda_flt_r;

  assign scl_win_s = {scl_hist_r, scl_sync_r[SYNC_STAGES-1]};
  assign sda_win_s = {sda_hist_r, sda_sync_r[SYNC_STAGES-1]};

  // Filtered level follows the input only once the whole window agrees.
  always_comb begin
    scl_f_s = scl_flt_r;
    sda_f_s = sda_flt_r;
    if (&scl_win_s) begin
      scl_f_s = 1'b1;
    end else if (~|scl_win_s) begin
      scl_f_s = 1'b0;
    end else begin
      scl_f_s = scl_flt_r;
    end
    if (&sda_win_s) begin
      sda_f_s = 1'b1;
    end else if (~|sda_win_s) begin
      sda_f_s = 1'b0;
    end else begin
      sda_f_s = sda_flt_r;
    end
  end

  // Sample history and held filter outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_r <= {(FILTER_LEN-1){1'b1}};
      sda_hist_r <= {(FILTER_LEN-1){1'b1}};
      scl_flt_r  <= 1'b1;
      sda_flt_r  <= 1'b1;
    end else begin
      scl_hist_r <= scl_win_s[FILTER_LEN-2:0];
      sda_hist_r <= sda_win_s[FILTER_LEN-2:0];
      scl_flt_r  <= scl_f_s;
      sda_flt_r  <= sda_f_s;
    end
  end
`else
  assign scl_f_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_f_s = sda_sync_r[SYNC_STAGES-1];
`endif

  // One-flop delayed copy of the conditioned lines for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d_r <= 1'b1;
      sda_d_r <= 1'b1;
    end else begin
      scl_d_r <= scl_f_s;
      sda_d_r <= sda_f_s;
    end
  end

  assign scl_rise_s = scl_f_s & ~scl_d_r;
  assign scl_fall_s = ~scl_f_s & scl_d_r;
  assign start_s    = scl_f_s & scl_d_r & sda_d_r & ~sda_f_s;
  assign stop_s     = scl_f_s & scl_d_r & ~sda_d_r & sda_f_s;

  state_t         state_r, state_s;
  logic [2:0]     bit_cnt_r, bit_cnt_s;
  logic           byte_full_r, byte_full_s;
  logic [BCW-1:0] byte_cnt_r, byte_cnt_s;
  logic [7:0]     shift_r, shift_s;
  logic           oe_r, oe_s;
  logic           bsy_r, bsy_s;
  logic           ack_done_r, ack_done_s;
  logic           fe_s, load_s, store_s;
  logic           dv_r, fe_r;
  logic [7:0]     staging_r [NUM_BYTES];

  // Protocol state and counters register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      byte_full_r <= 1'b0;
      byte_cnt_r  <= '0;
      shift_r     <= 8'h00;
      oe_r        <= 1'b0;
      bsy_r       <= 1'b0;
      ack_done_r  <= 1'b0;
      dv_r        <= 1'b0;
      fe_r        <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      byte_full_r <= byte_full_s;
      byte_cnt_r  <= byte_cnt_s;
      shift_r     <= shift_s;
      oe_r        <= oe_s;
      bsy_r       <= bsy_s;
      ack_done_r  <= ack_done_s;
      dv_r        <= load_s;
      fe_r        <= fe_s;
    end
  end

  // Next-state logic: STOP first, then START, then per-state bit handling.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    byte_full_s = byte_full_r;
    byte_cnt_s  = byte_cnt_r;
    shift_s     = shift_r;
    oe_s        = oe_r;
    bsy_s       = bsy_r;
    ack_done_s  = ack_done_r;
    fe_s        = 1'b0;
    load_s      = 1'b0;
    store_s     = 1'b0;
    if (stop_s && (state_r != IDLE)) begin
      // The STOP's own SCL rise shifts a stray bit in DATA; it is harmless.
      if ((state_r == DATA) && (byte_cnt_r == LAST_CNT) && ack_done_r) begin
        load_s = 1'b1;
      end else if (bsy_r) begin
        fe_s = 1'b1;
      end else begin
        fe_s = 1'b0;
      end
      bsy_s   = 1'b0;
      oe_s    = 1'b0;
      state_s = IDLE;
    end else if (start_s) begin
      if ((state_r != IDLE) && bsy_r && (byte_cnt_r != '0)) begin
        fe_s = 1'b1;
      end else begin
        fe_s = 1'b0;
      end
      state_s     = ADDR;
      bit_cnt_s   = 3'd0;
      byte_full_s = 1'b0;
      byte_cnt_s  = '0;
      ack_done_s  = 1'b0;
      oe_s        = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          oe_s = 1'b0;
        end
        ADDR, DATA: begin
          if (scl_rise_s) begin
            shift_s = {shift_r[6:0], sda_f_s};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_s   = 3'd0;
              byte_full_s = 1'b1;
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else if (scl_fall_s && byte_full_r) begin
            byte_full_s = 1'b0;
            if (state_r == ADDR) begin
              if ((shift_r[7:1] == own_address) && (shift_r[0] == 1'b0)) begin
                oe_s    = 1'b1;
                bsy_s   = 1'b1;
                state_s = ADDR_ACK;
              end else begin
                oe_s    = 1'b0;
                bsy_s   = 1'b0;
                state_s = IGNORE;
              end
            end else if (byte_cnt_r == LAST_CNT) begin
              // Overrun byte: NACK by release and abandon the frame.
              fe_s    = 1'b1;
              bsy_s   = 1'b0;
              state_s = IGNORE;
            end else begin
              store_s    = 1'b1;
              byte_cnt_s = byte_cnt_r + BCW'(1);
              oe_s       = 1'b1;
              ack_done_s = 1'b0;
              state_s    = DATA_ACK;
            end
          end else begin
            state_s = state_r;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall_s) begin
            oe_s       = 1'b0;
            bit_cnt_s  = 3'd0;
            ack_done_s = (state_r == DATA_ACK);
            state_s    = DATA;
          end else begin
            state_s = state_r;
          end
        end
        IGNORE: begin
          oe_s = 1'b0;
        end
        default: begin
          oe_s    = 1'b0;
          bsy_s   = 1'b0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // Byte staging buffer, written at each ACKed data byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        staging_r[i] <= 8'h00;
      end
    end else if (store_s) begin
      staging_r[byte_cnt_r] <= shift_r;
    end
  end

  // Atomic update of all five channel words on an accepted STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_data    <= 16'h0000;
      red_data      <= 16'h0000;
      green_data    <= 16'h0000;
      blue_data     <= 16'h0000;
      infrared_data <= 16'h0000;
    end else if (load_s) begin
      clear_data    <= map_word(endian, staging_r[0], staging_r[1]);
      red_data      <= map_word(endian, staging_r[2], staging_r[3]);
      green_data    <= map_word(endian, staging_r[4], staging_r[5]);
      blue_data     <= map_word(endian, staging_r[6], staging_r[7]);
      infrared_data <= map_word(endian, staging_r[8], staging_r[9]);
    end
  end

  assign sda_oe      = oe_r;
  assign bsy         = bsy_r;
  assign data_valid  = dv_r;
  assign frame_error = fe_r;

endmodule

// File: tb/tb_i2c_color_slave_rx.sv
// Directed self-checking bench for i2c_color_slave_rx: a behavioural I2C
// master drives SCL/SDA over an open-drain bus model and each scenario task
// compares DUT outputs against hand-computed values.
module tb_i2c_color_slave_rx;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [6:0]  own_address = 7'h29;
  logic        endian = 1'b1;
  logic [15:0] clear_data, red_data, green_data, blue_data, infrared_data;
  logic        data_valid, bsy, frame_error;
  wire         sda_in = sda_m & ~sda_oe;

  logic [7:0] frame_bytes [11] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                                   8'hDE, 8'hF0, 8'h11, 8'h22, 8'hAA};

  int total = 0;
  int bad = 0;
  int dv_cnt, fe_cnt, oe_cnt, bsy_cnt;
  logic clr_mon = 1'b0;

  i2c_color_slave_rx dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .own_address(own_address), .endian(endian),
    .clear_data(clear_data), .red_data(red_data), .green_data(green_data),
    .blue_data(blue_data), .infrared_data(infrared_data),
    .data_valid(data_valid), .bsy(bsy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Pulse/level monitors, cleared at the start of each scenario.
  always @(posedge clk) begin
    if (clr_mon) begin
      dv_cnt <= 0; fe_cnt <= 0; oe_cnt <= 0; bsy_cnt <= 0;
    end else begin
      if (data_valid)  dv_cnt  <= dv_cnt + 1;
      if (frame_error) fe_cnt  <= fe_cnt + 1;
      if (sda_oe)      oe_cnt  <= oe_cnt + 1;
      if (bsy)         bsy_cnt <= bsy_cnt + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_monitors();
    clr_mon = 1'b1;
    wait_clk(1);
    clr_mon = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q + 8);
  endtask

  // Writes one byte MSB first; spike_bit >= 0 injects a 1-clk SCL low glitch.
  task automatic write_byte(input logic [7:0] b, input int spike_bit, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clk(Q);
      scl = 1'b1;
      if (i == spike_bit) begin
        wait_clk(Q); scl = 1'b0; wait_clk(1); scl = 1'b1; wait_clk(Q - 1);
      end else begin
        wait_clk(2 * Q);
      end
      scl = 1'b0; wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    ack = ~sda_in;
    wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic send_data(input int n, input int spike_bit, inout int acks);
    logic a;
    for (int i = 0; i < n; i++) begin
      write_byte(frame_bytes[i], (i == 0) ? spike_bit : -1, a);
      acks += int'(a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    clear_monitors();
    wait_clk(3);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL reset_bsy got=%b exp=0", bsy); end
    total++; if ({data_valid, frame_error} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {data_valid, frame_error}); end
    total++; if ({clear_data, red_data, green_data, blue_data, infrared_data} !== 80'h0) begin
      bad++; $display("FAIL reset_words got=%h exp=0", {clear_data, red_data, green_data, blue_data, infrared_data});
    end
  endtask

  task automatic full_frame(input logic end_sel, input int spike_bit, output int acks);
    logic a;
    endian = end_sel;
    acks = 0;
    clear_monitors();
    i2c_start();
    write_byte(8'h52, -1, a);
    acks += int'(a);
    send_data(10, spike_bit, acks);
    total++; if (bsy !== 1'b1) begin bad++; $display("FAIL frame_bsy_high got=%b exp=1", bsy); end
    i2c_stop();
  endtask

  task automatic test_nominal();
    int acks;
    full_frame(1'b1, -1, acks);
    total++; if (acks !== 11) begin bad++; $display("FAIL nominal_acks got=%0d exp=11", acks); end
    total++; if (clear_data !== 16'h1234) begin bad++; $display("FAIL nominal_clear got=%h exp=1234", clear_data); end
    total++; if (red_data !== 16'h5678) begin bad++; $display("FAIL nominal_red got=%h exp=5678", red_data); end
    total++; if (green_data !== 16'h9ABC) begin bad++; $display("FAIL nominal_green got=%h exp=9abc", green_data); end
    total++; if (blue_data !== 16'hDEF0) begin bad++; $display("FAIL nominal_blue got=%h exp=def0", blue_data); end
    total++; if (infrared_data !== 16'h1122) begin bad++; $display("FAIL nominal_ir got=%h exp=1122", infrared_data); end
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL nominal_dv_count got=%0d exp=1", dv_cnt); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL nominal_fe_count got=%0d exp=0", fe_cnt); end
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL nominal_bsy_low got=%b exp=0", bsy); end
  endtask

  task automatic test_endian0();
    int acks;
    full_frame(1'b0, -1, acks);
    total++; if (clear_data !== 16'h3412) begin bad++; $display("FAIL le_clear got=%h exp=3412", clear_data); end
    total++; if (red_data !== 16'h7856) begin bad++; $display("FAIL le_red got=%h exp=7856", red_data); end
    total++; if (blue_data !== 16'hF0DE) begin bad++; $display("FAIL le_blue got=%h exp=f0de", blue_data); end
    total++; if (infrared_data !== 16'h2211) begin bad++; $display("FAIL le_ir got=%h exp=2211", infrared_data); end
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL le_dv_count got=%0d exp=1", dv_cnt); end
  endtask

  task automatic test_addr_mismatch();
    int acks;
    logic a;
    endian = 1'b1;
    acks = 0;
    clear_monitors();
    i2c_start();
    write_byte(8'h54, -1, a);
    acks += int'(a);
    send_data(10, -1, acks);
    i2c_stop();
    total++; if (acks !== 0) begin bad++; $display("FAIL mismatch_acks got=%0d exp=0", acks); end
    total++; if (oe_cnt !== 0) begin bad++; $display("FAIL mismatch_sda_oe_cycles got=%0d exp=0", oe_cnt); end
    total++; if (bsy_cnt !== 0) begin bad++; $display("FAIL mismatch_bsy_cycles got=%0d exp=0", bsy_cnt); end
    total++; if (dv_cnt !== 0) begin bad++; $display("FAIL mismatch_dv got=%0d exp=0", dv_cnt); end
    total++; if (clear_data !== 16'h3412) begin bad++; $display("FAIL mismatch_clear_kept got=%h exp=3412", clear_data); end
  endtask

  task automatic test_early_stop();
    int acks;
    logic a;
    endian = 1'b1;
    acks = 0;
    clear_monitors();
    i2c_start();
    write_byte(8'h52, -1, a);
    acks += int'(a);
    send_data(4, -1, acks);
    i2c_stop();
    total++; if (acks !== 5) begin bad++; $display("FAIL early_acks got=%0d exp=5", acks); end
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL early_fe got=%0d exp=1", fe_cnt); end
    total++; if (dv_cnt !== 0) begin bad++; $display("FAIL early_dv got=%0d exp=0", dv_cnt); end
    total++; if (infrared_data !== 16'h2211) begin bad++; $display("FAIL early_ir_kept got=%h exp=2211", infrared_data); end
  endtask

  task automatic test_restart();
    int acks;
    logic a;
    endian = 1'b1;
    acks = 0;
    clear_monitors();
    i2c_start();
    write_byte(8'h52, -1, a);
    acks += int'(a);
    send_data(3, -1, acks);
    i2c_start();
    write_byte(8'h52, -1, a);
    acks += int'(a);
    send_data(10, -1, acks);
    i2c_stop();
    total++; if (acks !== 15) begin bad++; $display("FAIL restart_acks got=%0d exp=15", acks); end
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL restart_fe got=%0d exp=1", fe_cnt); end
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL restart_dv got=%0d exp=1", dv_cnt); end
    total++; if (clear_data !== 16'h1234) begin bad++; $display("FAIL restart_clear got=%h exp=1234", clear_data); end
    total++; if (green_data !== 16'h9ABC) begin bad++; $display("FAIL restart_green got=%h exp=9abc", green_data); end
  endtask

  task automatic test_overrun();
    int acks;
    logic a;
    endian = 1'b0;
    acks = 0;
    clear_monitors();
    i2c_start();
    write_byte(8'h52, -1, a);
    acks += int'(a);
    send_data(11, -1, acks);
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL overrun_bsy got=%b exp=0", bsy); end
    i2c_stop();
    total++; if (acks !== 11) begin bad++; $display("FAIL overrun_acks got=%0d exp=11", acks); end
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL overrun_fe got=%0d exp=1", fe_cnt); end
    total++; if (dv_cnt !== 0) begin bad++; $display("FAIL overrun_dv got=%0d exp=0", dv_cnt); end
    total++; if (clear_data !== 16'h1234) begin bad++; $display("FAIL overrun_clear_kept got=%h exp=1234", clear_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic a;
    logic [7:0] b;
    endian = 1'b1;
    b = 8'h12;
    i2c_start();
    write_byte(8'h52, -1, a);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clk(Q);
      scl = 1'b1;   wait_clk(2 * Q);
      scl = 1'b0;   wait_clk(Q);
    end
    sda_m = 1'b1;
    total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL midrst_ack_driven got=%b exp=1", sda_oe); end
    rst = 1'b1;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL midrst_sda_oe got=%b exp=0", sda_oe); end
    total++; if (bsy !== 1'b0) begin bad++; $display("FAIL midrst_bsy got=%b exp=0", bsy); end
    wait_clk(2);
    rst = 1'b0;
    scl = 1'b1;
    wait_clk(Q);
    total++; if (clear_data !== 16'h0000) begin bad++; $display("FAIL midrst_clear got=%h exp=0000", clear_data); end
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    int acks;
    full_frame(1'b1, 4, acks);
    total++; if (acks !== 11) begin bad++; $display("FAIL glitch_acks got=%0d exp=11", acks); end
    total++; if (clear_data !== 16'h1234) begin bad++; $display("FAIL glitch_clear got=%h exp=1234", clear_data); end
    total++; if (dv_cnt !== 1) begin bad++; $display("FAIL glitch_dv got=%0d exp=1", dv_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_endian0();
    test_addr_mismatch();
    test_early_stop();
    test_restart();
    test_overrun();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
